// File: rtl/gaussian_stage.sv
// gaussian_stage: 5-tap [1 4 6 4 1]/16 horizontal blur with per-row zero padding and an output FIFO.
// Define GAUSS_BYPASS_EN to add a bypass port that passes the centre tap through unfiltered.
module gaussian_stage #(
  parameter int DATA_W = 8,
  parameter int IMG_W = 400,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef GAUSS_BYPASS_EN
  input  logic                          bypass,
`endif
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_rd_en,
  input  logic                          out_rd_en,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  output logic                          out_empty,
  output logic [$clog2(FIFO_DEPTH):0]   out_count
);
  localparam int CW = $clog2(IMG_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = DATA_W + 4;
  typedef enum logic {S_RUN, S_PAD} state_t;
  state_t state, state_d;
  logic [CW-1:0] col, col_d;
  logic pad, pad_d, shift, prime, room, byp, v0, b0, v1, wr, rd;
  logic [DATA_W-1:0] taps [5];
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [SW-1:0] sum, sum_r, rnd;
  logic [AW-1:0] wptr, rptr;
`ifdef GAUSS_BYPASS_EN
  assign byp = bypass;
`else
  assign byp = 1'b0;
`endif
  // three entries of slack absorb the shifts still travelling down the pipeline
  assign room = out_count <= (AW+1)'(FIFO_DEPTH - 3);
  assign prime = state == S_RUN && col < CW'(2);
  assign sum = SW'(taps[0]) + SW'(taps[4]) + (SW'(taps[1]) << 2) + (SW'(taps[3]) << 2)
             + (SW'(taps[2]) << 2) + (SW'(taps[2]) << 1);
  assign rnd = sum_r + SW'(8);
  assign wr = v1;
  assign out_empty = out_count == '0;
  assign rd = out_rd_en & ~out_empty;
  always_comb begin
    state_d = state;
    col_d = col;
    pad_d = pad;
    in_rd_en = 1'b0;
    shift = 1'b0;
    if (state == S_RUN) begin
      in_rd_en = in_valid & room & ~rst;
      shift = in_rd_en;
      if (shift) begin
        col_d = (col == CW'(IMG_W - 1)) ? '0 : col + CW'(1);
        state_d = (col == CW'(IMG_W - 1)) ? S_PAD : S_RUN;
      end
    end else if (room) begin
      shift = 1'b1;
      pad_d = ~pad;
      state_d = pad ? S_RUN : S_PAD;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_RUN;
      col <= '0;
      pad <= 1'b0;
      v0 <= 1'b0;
      b0 <= 1'b0;
      v1 <= 1'b0;
      sum_r <= '0;
      for (int i = 0; i < 5; i++) taps[i] <= '0;
    end else begin
      state <= state_d;
      col <= col_d;
      pad <= pad_d;
      v0 <= shift & ~prime;
      v1 <= v0;
      // bypass folds the centre tap into the sum so rounding recovers it exactly
      sum_r <= b0 ? SW'(taps[2]) << 4 : sum;
      if (shift) begin
        b0 <= byp;
        for (int i = 0; i < 4; i++) taps[i] <= taps[i+1];
        taps[4] <= state == S_RUN ? in_data : '0;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) begin
        rptr <= rptr + AW'(1);
        out_data <= mem[rptr];
      end
      out_valid <= rd;
      out_count <= out_count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= rnd[SW-1:4];
endmodule
